// File: rtl/interrupt_sequencer_if.sv
// Bus, stack-pointer and PC hand-off signals shared between interrupt_sequencer and the CPU core.
// The sequencer side is the bus master while busy; the core side drives status and memory data.
interface interrupt_sequencer_if;
    logic        rdy;
    logic        irq;
    logic        nmi;
    logic        opcode_boundary;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [6:0]  status;
    logic [7:0]  data_in;

    logic        busy;
    logic [15:0] address;
    logic        rw;
    logic [7:0]  data_out;
    logic        sp_dec;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        set_i;

    modport master (
        input  rdy, irq, nmi, opcode_boundary, pc, sp, status, data_in,
        output busy, address, rw, data_out, sp_dec, pc_load, pc_value, set_i
    );

    modport slave (
        output rdy, irq, nmi, opcode_boundary, pc, sp, status, data_in,
        input  busy, address, rw, data_out, sp_dec, pc_load, pc_value, set_i
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ entry sequencer: takes the bus at an opcode boundary, pushes PC and P,
// fetches the vector and hands the new PC back. Priority is reset > NMI > IRQ.
module interrupt_sequencer (
    input  logic                  clk,
    input  logic                  res,
    interrupt_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StReset,
        StRst1,
        StRst2,
        StRst3,
        StIdle,
        StPushPch,
        StPushPcl,
        StPushP,
        StVecLo,
        StVecHi,
        StLoad
    } state_e;

    typedef enum logic [1:0] {
        VecReset = 2'd0,
        VecNmi   = 2'd1,
        VecIrq   = 2'd2
    } vec_sel_e;

    state_e      state_q, state_d;
    vec_sel_e    vec_sel_q, vec_sel_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic [15:0] pc_saved_q, pc_saved_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic [7:0]  vec_hi_q, vec_hi_d;

    logic        irq_pend;
    logic        nmi_fall;
    logic [15:0] stack_addr;
    logic [15:0] vec_base;
    logic [7:0]  status_byte;
    logic        unused_status_b;

    assign irq_pend    = !bus.irq && !bus.status[2];
    assign nmi_fall    = nmi_prev_q && !bus.nmi;
    assign stack_addr  = {8'h01, bus.sp};
    // The pushed P always carries bit 5 set and the break bit clear for hardware entries.
    assign status_byte = {bus.status[6:5], 2'b10, bus.status[3:0]};
    assign unused_status_b = bus.status[4];

    always_comb begin
        case (vec_sel_q)
            VecNmi:  vec_base = 16'hFFFA;
            VecIrq:  vec_base = 16'hFFFE;
            default: vec_base = 16'hFFFC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= StReset;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            vec_sel_q  <= VecReset;
            pc_saved_q <= 16'h0000;
            vec_lo_q   <= 8'h00;
            vec_hi_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_pend_q <= nmi_pend_d;
            vec_sel_q  <= vec_sel_d;
            pc_saved_q <= pc_saved_d;
            vec_lo_q   <= vec_lo_d;
            vec_hi_q   <= vec_hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nmi_prev_d = bus.nmi;
        nmi_pend_d = nmi_pend_q;
        vec_sel_d  = vec_sel_q;
        pc_saved_d = pc_saved_q;
        vec_lo_d   = vec_lo_q;
        vec_hi_d   = vec_hi_q;

        if (bus.rdy) begin
            unique case (state_q)
                StReset: state_d = StRst1;
                StRst1:  state_d = StRst2;
                StRst2:  state_d = StRst3;
                StRst3:  state_d = StVecLo;
                StIdle: begin
                    if (bus.opcode_boundary && (nmi_pend_q || irq_pend)) begin
                        pc_saved_d = bus.pc;
                        state_d    = StPushPch;
                        if (nmi_pend_q) begin
                            vec_sel_d  = VecNmi;
                            nmi_pend_d = 1'b0;
                        end else begin
                            vec_sel_d  = VecIrq;
                        end
                    end
                end
                StPushPch: state_d = StPushPcl;
                StPushPcl: state_d = StPushP;
                StPushP: begin
                    state_d = StVecLo;
                    // A late NMI steals an IRQ entry that has not yet fetched its vector.
                    if (vec_sel_q == VecIrq && nmi_pend_q) begin
                        vec_sel_d  = VecNmi;
                        nmi_pend_d = 1'b0;
                    end
                end
                StVecLo: begin
                    vec_lo_d = bus.data_in;
                    state_d  = StVecHi;
                end
                StVecHi: begin
                    vec_hi_d = bus.data_in;
                    state_d  = StLoad;
                end
                StLoad:  state_d = StIdle;
                default: state_d = StReset;
            endcase
        end

        // Edge detection keeps running through rdy stalls; a new edge wins over a clear.
        if (nmi_fall) begin
            nmi_pend_d = 1'b1;
        end
    end

    always_comb begin
        bus.busy     = 1'b1;
        bus.address  = 16'h0000;
        bus.rw       = 1'b1;
        bus.data_out = 8'h00;
        bus.sp_dec   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.pc_value = 16'h0000;
        bus.set_i    = 1'b0;

        unique case (state_q)
            StIdle: bus.busy = 1'b0;
            StRst1, StRst2, StRst3: begin
                bus.address = stack_addr;
                bus.sp_dec  = 1'b1;
            end
            StPushPch: begin
                bus.address  = stack_addr;
                bus.rw       = 1'b0;
                bus.data_out = pc_saved_q[15:8];
                bus.sp_dec   = 1'b1;
            end
            StPushPcl: begin
                bus.address  = stack_addr;
                bus.rw       = 1'b0;
                bus.data_out = pc_saved_q[7:0];
                bus.sp_dec   = 1'b1;
            end
            StPushP: begin
                bus.address  = stack_addr;
                bus.rw       = 1'b0;
                bus.data_out = status_byte;
                bus.sp_dec   = 1'b1;
            end
            StVecLo: bus.address = vec_base;
            StVecHi: bus.address = vec_base | 16'h0001;
            StLoad: begin
                bus.pc_load  = 1'b1;
                bus.set_i    = 1'b1;
                bus.pc_value = {vec_hi_q, vec_lo_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: a CPU-side stack/memory model plus per-scenario expected
// bus-cycle lists built from the entry-sequence rules.
module tb_interrupt_sequencer;

    typedef logic [44:0] obs_t;

    localparam obs_t ObsIdle  = {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
    localparam obs_t ObsReset = {1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};

    logic clk;
    logic res;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] vmem [6];
    obs_t expq [$];

    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t obs();
        return {bus.busy, bus.address, bus.rw, bus.data_out, bus.sp_dec, bus.pc_load,
                bus.pc_value, bus.set_i};
    endfunction

    function automatic obs_t pk(input logic b, input logic [15:0] a, input logic r,
                                input logic [7:0] d, input logic s, input logic l,
                                input logic [15:0] v, input logic i);
        return {b, a, r, d, s, l, v, i};
    endfunction

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a >= 16'hFFFA) return vmem[3'(a - 16'hFFFA)];
        return 8'hEE;
    endfunction

    // One clock; afterwards the CPU model applies a stack decrement and returns read data.
    task automatic step();
        logic dec;
        dec = bus.sp_dec && bus.rdy;
        @(posedge clk);
        #1;
        if (dec) bus.sp = bus.sp - 8'd1;
        bus.data_in = mem_rd(bus.address);
        @(negedge clk);
    endtask

    task automatic add_vector(input logic [15:0] vec);
        expq.push_back(pk(1'b1, vec, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
        expq.push_back(pk(1'b1, vec + 16'd1, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0));
        expq.push_back(pk(1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b1,
                          {mem_rd(vec + 16'd1), mem_rd(vec)}, 1'b1));
        expq.push_back(ObsIdle);
    endtask

    task automatic build_entry(input logic [15:0] pc, input logic [7:0] sp,
                               input logic [6:0] st, input logic [15:0] vec);
        logic [7:0] p;
        logic [7:0] s1;
        logic [7:0] s2;
        p  = 8'h20 | ({1'b0, st} & 8'h0F) | (({1'b0, st} >> 5) << 6);
        s1 = sp - 8'd1;
        s2 = sp - 8'd2;
        expq.delete();
        expq.push_back(pk(1'b1, {8'h01, sp}, 1'b0, pc[15:8], 1'b1, 1'b0, 16'h0000, 1'b0));
        expq.push_back(pk(1'b1, {8'h01, s1}, 1'b0, pc[7:0], 1'b1, 1'b0, 16'h0000, 1'b0));
        expq.push_back(pk(1'b1, {8'h01, s2}, 1'b0, p, 1'b1, 1'b0, 16'h0000, 1'b0));
        add_vector(vec);
    endtask

    task automatic build_reset(input logic [7:0] sp);
        expq.delete();
        for (int k = 0; k < 3; k++) begin
            expq.push_back(pk(1'b1, {8'h01, 8'(sp - 8'(k))}, 1'b1, 8'h00, 1'b1, 1'b0,
                              16'h0000, 1'b0));
        end
        add_vector(16'hFFFC);
    endtask

    task automatic start_seq(input logic [15:0] pc, input logic [7:0] sp,
                             input logic [6:0] st, input logic irq_lvl);
        bus.pc              = pc;
        bus.sp              = sp;
        bus.status          = st;
        bus.irq             = irq_lvl;
        bus.opcode_boundary = 1'b1;
        step();
        bus.opcode_boundary = 1'b0;
        bus.irq             = 1'b1;
    endtask

    task automatic rand_vectors();
        for (int i = 0; i < 6; i++) vmem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        res     = 1'b1;
        bus.sp  = 8'h00;
        vmem[2] = 8'h00;
        vmem[3] = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obs() !== ObsReset) begin
                fails++;
                $display("FAIL reset_hold cyc%0d got %h want %h", i, obs(), ObsReset);
            end
        end
        res = 1'b0;
        build_reset(bus.sp);
        for (int k = 0; k < expq.size(); k++) begin
            step();
            tests++;
            if (obs() !== expq[k]) begin
                fails++;
                $display("FAIL reset_seq cyc%0d got %h want %h", k, obs(), expq[k]);
            end
        end
        tests++;
        if (bus.sp !== 8'hFD) begin
            fails++;
            $display("FAIL reset_sp got %h want fd", bus.sp);
        end
    endtask

    task automatic test_irq_entry();
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [6:0]  st;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                pc = 16'h1234;
                sp = 8'hFF;
                st = 7'b1000011;
            end else begin
                pc = 16'($urandom);
                sp = 8'($urandom);
                st = 7'($urandom) & 7'h7B;
                rand_vectors();
            end
            start_seq(pc, sp, st, 1'b0);
            build_entry(pc, sp, st, 16'hFFFE);
            for (int k = 0; k < expq.size(); k++) begin
                tests++;
                if (obs() !== expq[k]) begin
                    fails++;
                    $display("FAIL irq_entry it%0d cyc%0d got %h want %h", it, k, obs(), expq[k]);
                end
                step();
            end
            tests++;
            if (bus.sp !== 8'(sp - 8'd3)) begin
                fails++;
                $display("FAIL irq_sp it%0d got %h want %h", it, bus.sp, 8'(sp - 8'd3));
            end
        end
    endtask

    task automatic test_masked_irq();
        bus.status = 7'($urandom) | 7'h04;
        bus.irq    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.opcode_boundary = 1'b1;
            step();
            tests++;
            if (obs() !== ObsIdle) begin
                fails++;
                $display("FAIL masked_irq b%0d got %h want %h", i, obs(), ObsIdle);
            end
            bus.opcode_boundary = 1'b0;
            step();
        end
        bus.irq = 1'b1;
    endtask

    task automatic test_nmi_edge();
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [6:0]  st;
        pc = 16'($urandom);
        sp = 8'($urandom);
        st = 7'($urandom);
        rand_vectors();
        bus.nmi = 1'b0;
        step();
        start_seq(pc, sp, st, 1'b1);
        build_entry(pc, sp, st, 16'hFFFA);
        for (int k = 0; k < expq.size(); k++) begin
            tests++;
            if (obs() !== expq[k]) begin
                fails++;
                $display("FAIL nmi_entry cyc%0d got %h want %h", k, obs(), expq[k]);
            end
            step();
        end
        for (int i = 0; i < 11; i++) begin
            bus.opcode_boundary = (i % 4 == 1);
            step();
            tests++;
            if (obs() !== ObsIdle) begin
                fails++;
                $display("FAIL nmi_once cyc%0d got %h want %h", i, obs(), ObsIdle);
            end
        end
        bus.opcode_boundary = 1'b0;
        bus.nmi = 1'b1;
        step();
    endtask

    task automatic test_nmi_hijack();
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [6:0]  st;
        pc = 16'($urandom);
        sp = 8'($urandom);
        st = 7'($urandom) & 7'h7B;
        rand_vectors();
        start_seq(pc, sp, st, 1'b0);
        build_entry(pc, sp, st, 16'hFFFA);
        for (int k = 0; k < expq.size(); k++) begin
            tests++;
            if (obs() !== expq[k]) begin
                fails++;
                $display("FAIL hijack cyc%0d got %h want %h", k, obs(), expq[k]);
            end
            if (k == 1) bus.nmi = 1'b0;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            bus.opcode_boundary = 1'b1;
            step();
            tests++;
            if (obs() !== ObsIdle) begin
                fails++;
                $display("FAIL hijack_clear b%0d got %h want %h", i, obs(), ObsIdle);
            end
            bus.opcode_boundary = 1'b0;
            step();
        end
        bus.nmi = 1'b1;
        step();
    endtask

    task automatic test_freeze();
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [6:0]  st;
        pc = 16'($urandom);
        sp = 8'($urandom);
        st = 7'($urandom) & 7'h7B;
        rand_vectors();
        start_seq(pc, sp, st, 1'b0);
        build_entry(pc, sp, st, 16'hFFFE);
        for (int k = 0; k < expq.size(); k++) begin
            tests++;
            if (obs() !== expq[k]) begin
                fails++;
                $display("FAIL freeze_seq cyc%0d got %h want %h", k, obs(), expq[k]);
            end
            if (k == 1) begin
                bus.rdy = 1'b0;
                for (int f = 0; f < 4; f++) begin
                    step();
                    tests++;
                    if (obs() !== expq[1] || bus.sp !== 8'(sp - 8'd1)) begin
                        fails++;
                        $display("FAIL freeze_hold f%0d got %h sp %h want %h sp %h", f, obs(),
                                 bus.sp, expq[1], 8'(sp - 8'd1));
                    end
                end
                bus.rdy = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [6:0]  st;
        pc = 16'($urandom);
        sp = 8'($urandom);
        st = 7'($urandom) & 7'h7B;
        rand_vectors();
        start_seq(pc, sp, st, 1'b0);
        build_entry(pc, sp, st, 16'hFFFE);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs() !== expq[k]) begin
                fails++;
                $display("FAIL midres_pre cyc%0d got %h want %h", k, obs(), expq[k]);
            end
            if (k < 3) step();
        end
        res = 1'b1;
        step();
        tests++;
        if (obs() !== ObsReset) begin
            fails++;
            $display("FAIL midres_reset got %h want %h", obs(), ObsReset);
        end
        res = 1'b0;
        build_reset(bus.sp);
        for (int k = 0; k < expq.size(); k++) begin
            step();
            tests++;
            if (obs() !== expq[k]) begin
                fails++;
                $display("FAIL midres_seq cyc%0d got %h want %h", k, obs(), expq[k]);
            end
        end
    endtask

    // Random back-to-back entries: IRQ only, NMI only, or both pending (NMI must win).
    task automatic test_back_to_back();
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [6:0]  st;
        int unsigned kind;
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 2);
            pc   = 16'($urandom);
            sp   = 8'($urandom);
            st   = (kind == 1) ? 7'($urandom) : (7'($urandom) & 7'h7B);
            rand_vectors();
            if (kind != 0) begin
                bus.nmi = 1'b0;
                step();
                tests++;
                if (obs() !== ObsIdle) begin
                    fails++;
                    $display("FAIL b2b_pend it%0d got %h want %h", it, obs(), ObsIdle);
                end
            end
            start_seq(pc, sp, st, (kind == 1));
            bus.nmi = 1'b1;
            build_entry(pc, sp, st, (kind == 0) ? 16'hFFFE : 16'hFFFA);
            for (int k = 0; k < expq.size(); k++) begin
                tests++;
                if (obs() !== expq[k]) begin
                    fails++;
                    $display("FAIL b2b it%0d kind%0d cyc%0d got %h want %h", it, kind, k, obs(),
                             expq[k]);
                end
                if (k < expq.size() - 1) step();
            end
        end
    endtask

    initial begin
        res                 = 1'b1;
        bus.rdy             = 1'b1;
        bus.irq             = 1'b1;
        bus.nmi             = 1'b1;
        bus.opcode_boundary = 1'b0;
        bus.pc              = 16'h0000;
        bus.sp              = 8'h00;
        bus.status          = 7'h00;
        bus.data_in         = 8'h00;
        for (int i = 0; i < 6; i++) vmem[i] = 8'h00;
        @(negedge clk);

        test_reset();
        test_irq_entry();
        test_masked_irq();
        test_nmi_edge();
        test_nmi_hijack();
        test_freeze();
        test_mid_reset();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
